// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : Pipeline M stage. Issues data-memory requests for loads and
//               stores, stalls the pipeline until the memory acknowledges,
//               flags misaligned accesses, and registers results into the
//               M/W pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage (
    input  logic        CLK,
    input  logic        RESET,
    // M-stage instruction
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    // data memory
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [3:0]  DmemBe,
    output logic [31:0] DmemWData,
    input  logic        DmemAck,
    input  logic [31:0] DmemRData,
    // hazard / status
    output logic        StallM,
    output logic        MisalignM,
    // writeback stage
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW
);

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_load;
    logic        mem_op;
    logic        misalign;
    logic [3:0]  new_be;
    logic [31:0] new_wdata;
    logic        hold_we;
    logic [31:0] hold_addr;
    logic [3:0]  hold_be;
    logic [31:0] hold_wdata;
    logic [31:0] load_data;
    logic        done;

    assign is_load = (ResultSrcM == RES_LOAD);
    assign mem_op  = MemWriteM | is_load;

    // Funct3[1:0] encodes access size for both signed and unsigned variants
    assign misalign = mem_op &&
                      (((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                       ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00)));

    // Byte enables and replicated store lanes for a new request
    always_comb begin
        new_be    = 4'b1111;
        new_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Funct3M)
                3'b000: begin
                    new_be    = 4'b0001 << ALUResultM[1:0];
                    new_wdata = {4{WriteDataM[7:0]}};
                end
                3'b001: begin
                    new_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    new_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    new_be    = 4'b1111;
                    new_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Snapshot the request while idle so it is held stable during WAIT
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_we    <= 1'b0;
            hold_addr  <= 32'd0;
            hold_be    <= 4'd0;
            hold_wdata <= 32'd0;
        end else if (state == S_IDLE) begin
            hold_we    <= MemWriteM;
            hold_addr  <= {ALUResultM[31:2], 2'b00};
            hold_be    <= new_be;
            hold_wdata <= new_wdata;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and memory-side / stall outputs
    always_comb begin
        state_next = state;
        DmemReq    = 1'b0;
        DmemWe     = MemWriteM;
        DmemAddr   = {ALUResultM[31:2], 2'b00};
        DmemBe     = new_be;
        DmemWData  = new_wdata;
        StallM     = 1'b0;
        MisalignM  = 1'b0;
        if (!RESET) begin
            case (state)
                S_IDLE: begin
                    MisalignM = misalign;
                    if (mem_op && !misalign) begin
                        DmemReq = 1'b1;
                        if (!DmemAck) begin
                            StallM     = 1'b1;
                            state_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    DmemReq   = 1'b1;
                    DmemWe    = hold_we;
                    DmemAddr  = hold_addr;
                    DmemBe    = hold_be;
                    DmemWData = hold_wdata;
                    StallM    = ~DmemAck;
                    if (DmemAck) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // An acknowledge only counts while a request is outstanding
    assign done = DmemReq & DmemAck;

    // Select and extend the addressed lane of the returned word
    always_comb begin
        load_data = DmemRData;
        case (Funct3M)
            3'b000: case (ALUResultM[1:0])
                2'b00:   load_data = {{24{DmemRData[7]}},  DmemRData[7:0]};
                2'b01:   load_data = {{24{DmemRData[15]}}, DmemRData[15:8]};
                2'b10:   load_data = {{24{DmemRData[23]}}, DmemRData[23:16]};
                default: load_data = {{24{DmemRData[31]}}, DmemRData[31:24]};
            endcase
            3'b001: load_data = ALUResultM[1] ? {{16{DmemRData[31]}}, DmemRData[31:16]}
                                              : {{16{DmemRData[15]}}, DmemRData[15:0]};
            3'b100: case (ALUResultM[1:0])
                2'b00:   load_data = {24'd0, DmemRData[7:0]};
                2'b01:   load_data = {24'd0, DmemRData[15:8]};
                2'b10:   load_data = {24'd0, DmemRData[23:16]};
                default: load_data = {24'd0, DmemRData[31:24]};
            endcase
            3'b101: load_data = ALUResultM[1] ? {16'd0, DmemRData[31:16]}
                                              : {16'd0, DmemRData[15:0]};
            default: load_data = DmemRData;
        endcase
    end

    // M/W pipeline register: bubble while stalled, otherwise advance
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
            PCPlus4W   <= 32'd0;
            ReadDataW  <= 32'd0;
            ALUResultW <= 32'd0;
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~misalign;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            PCPlus4W   <= PCPlus4M;
            ALUResultW <= ALUResultM;
            if (done && is_load) begin
                ReadDataW <= load_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_stage
// Description : Directed, scoreboard-checked bench for memory_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic        DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemBe;
    logic        DmemAck;
    logic [31:0] DmemRData;
    logic        StallM, MisalignM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W, ReadDataW, ALUResultW;

    memory_access_stage dut (
        .CLK(CLK), .RESET(RESET),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .DmemReq(DmemReq), .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemBe(DmemBe),
        .DmemWData(DmemWData), .DmemAck(DmemAck), .DmemRData(DmemRData),
        .StallM(StallM), .MisalignM(MisalignM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .PCPlus4W(PCPlus4W), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic [31:0] alu;
    } wexp_t;

    wexp_t sb[$];
    wexp_t w_model;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: the W register changes on every edge; compare against the oldest expectation
    always @(posedge CLK) begin
        wexp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("W.RegWrite",  {31'd0, RegWriteW},  {31'd0, e.rw});
            chk("W.ResultSrc", {30'd0, ResultSrcW}, {30'd0, e.rs});
            chk("W.Rd",        {27'd0, RdW},        {27'd0, e.rd});
            chk("W.PCPlus4",   PCPlus4W,            e.pc4);
            chk("W.ReadData",  ReadDataW,           e.rdata);
            chk("W.ALUResult", ALUResultW,          e.alu);
        end
    end

    // Expect the current M op to land in W at the coming edge
    task automatic exp_update(input logic mis, input logic load_done, input logic [31:0] rd_val);
        w_model.rw  = RegWriteM & ~mis;
        w_model.rs  = ResultSrcM;
        w_model.rd  = RdM;
        w_model.pc4 = PCPlus4M;
        w_model.alu = ALUResultM;
        if (load_done) w_model.rdata = rd_val;
        sb.push_back(w_model);
    endtask

    // Expect a bubble at the coming edge
    task automatic exp_bubble();
        w_model.rw = 1'b0;
        sb.push_back(w_model);
    endtask

    task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                          input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] pc4);
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        RdM = rd; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        set_op(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        DmemAck = 1'b0; DmemRData = 32'd0;
        w_model = '0;
        repeat (2) @(negedge CLK);
        chk("rst.DmemReq",   {31'd0, DmemReq},   32'd0);
        chk("rst.StallM",    {31'd0, StallM},    32'd0);
        chk("rst.MisalignM", {31'd0, MisalignM}, 32'd0);
        chk("rst.RegWriteW", {31'd0, RegWriteW}, 32'd0);
        chk("rst.ALUResultW", ALUResultW,        32'd0);
        RESET = 1'b0;

        // ADD, non-memory
        set_op(1'b1, 2'b00, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h104);
        #1;
        chk("add.DmemReq", {31'd0, DmemReq}, 32'd0);
        chk("add.StallM",  {31'd0, StallM},  32'd0);
        exp_update(1'b0, 1'b0, 32'd0);
        @(negedge CLK);

        // LB at 0x103, three wait cycles
        set_op(1'b1, 2'b01, 1'b0, 3'b000, 5'd7, 32'h103, 32'h0, 32'h108);
        DmemAck = 1'b0; DmemRData = 32'h80FF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb.DmemReq",  {31'd0, DmemReq}, 32'd1);
            chk("lb.DmemAddr", DmemAddr,         32'h100);
            chk("lb.DmemBe",   {28'd0, DmemBe},  32'hF);
            chk("lb.DmemWe",   {31'd0, DmemWe},  32'd0);
            chk("lb.StallM",   {31'd0, StallM},  32'd1);
            exp_bubble();
            @(negedge CLK);
        end
        DmemAck = 1'b1;
        #1;
        chk("lb.ack.StallM", {31'd0, StallM}, 32'd0);
        exp_update(1'b0, 1'b1, 32'hFFFF_FF80);
        @(negedge CLK);
        DmemAck = 1'b0;

        // SH at 0x202, zero-wait
        set_op(1'b0, 2'b00, 1'b1, 3'b001, 5'd0, 32'h202, 32'hABCD_1234, 32'h10C);
        DmemAck = 1'b1;
        #1;
        chk("sh.DmemReq",   {31'd0, DmemReq}, 32'd1);
        chk("sh.DmemAddr",  DmemAddr,         32'h200);
        chk("sh.DmemBe",    {28'd0, DmemBe},  32'hC);
        chk("sh.DmemWData", DmemWData,        32'h1234_1234);
        chk("sh.DmemWe",    {31'd0, DmemWe},  32'd1);
        chk("sh.StallM",    {31'd0, StallM},  32'd0);
        exp_update(1'b0, 1'b0, 32'd0);
        @(negedge CLK);

        // SB at 0x001 with one wait cycle: request must hold steady in WAIT
        set_op(1'b0, 2'b00, 1'b1, 3'b000, 5'd0, 32'h001, 32'h0000_00A5, 32'h110);
        DmemAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("sb.DmemBe",    {28'd0, DmemBe},  32'h2);
            chk("sb.DmemWData", DmemWData,        32'hA5A5_A5A5);
            chk("sb.DmemAddr",  DmemAddr,         32'h0);
            chk("sb.StallM",    {31'd0, StallM},  {31'd0, (i == 0)});
            if (i == 0) begin
                exp_bubble();
                @(negedge CLK);
                DmemAck = 1'b1;
            end
        end
        exp_update(1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        DmemAck = 1'b0;

        // LW at 0x301, misaligned
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 5'd9, 32'h301, 32'h0, 32'h114);
        #1;
        chk("lw.MisalignM", {31'd0, MisalignM}, 32'd1);
        chk("lw.DmemReq",   {31'd0, DmemReq},   32'd0);
        chk("lw.StallM",    {31'd0, StallM},    32'd0);
        exp_update(1'b1, 1'b0, 32'd0);
        @(negedge CLK);

        // LHU at 0x402, zero-wait
        set_op(1'b1, 2'b01, 1'b0, 3'b101, 5'd10, 32'h402, 32'h0, 32'h118);
        DmemAck = 1'b1; DmemRData = 32'hF00D_0000;
        #1;
        chk("lhu.DmemReq",   {31'd0, DmemReq},   32'd1);
        chk("lhu.StallM",    {31'd0, StallM},    32'd0);
        chk("lhu.MisalignM", {31'd0, MisalignM}, 32'd0);
        exp_update(1'b0, 1'b1, 32'h0000_F00D);
        @(negedge CLK);

        // LH at 0x000, zero-wait, sign extension of low half
        set_op(1'b1, 2'b01, 1'b0, 3'b001, 5'd11, 32'h0, 32'h0, 32'h11C);
        DmemRData = 32'h1234_8001;
        exp_update(1'b0, 1'b1, 32'hFFFF_8001);
        @(negedge CLK);

        // LW at 0x500, reset while waiting
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 5'd12, 32'h500, 32'h0, 32'h120);
        DmemAck = 1'b0;
        exp_bubble();
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        chk("rstw.DmemReq",    {31'd0, DmemReq},   32'd0);
        chk("rstw.StallM",     {31'd0, StallM},    32'd0);
        chk("rstw.RdW",        {27'd0, RdW},       32'd0);
        chk("rstw.ReadDataW",  ReadDataW,          32'd0);
        chk("rstw.PCPlus4W",   PCPlus4W,           32'd0);
        w_model = '0;
        set_op(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        DmemAck = 1'b1; DmemRData = 32'hDEAD_BEEF;
        #1;
        chk("late_ack.DmemReq", {31'd0, DmemReq}, 32'd0);
        chk("late_ack.StallM",  {31'd0, StallM},  32'd0);
        exp_update(1'b0, 1'b0, 32'd0);
        @(negedge CLK);
        DmemAck = 1'b0;

        // First op after reset is accepted immediately
        set_op(1'b1, 2'b00, 1'b0, 3'b000, 5'd3, 32'hCAFE, 32'h0, 32'h200);
        exp_update(1'b0, 1'b0, 32'd0);
        @(negedge CLK);

        set_op(1'b0, 2'b00, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: CLK input 1, rising-edge clock; RESET input 1, asynchronous active-high reset.
REQ-002 The block SHALL have these M-stage inputs: RegWriteM in 1; ResultSrcM in 2 (00 ALU, 01 load, 10 PC+4); MemWriteM in 1; Funct3M in 3; RdM in 5; ALUResultM in 32 (address or result); WriteDataM in 32; PCPlus4M in 32.
REQ-003 The block SHALL have these data-memory ports: DmemReq out 1; DmemWe out 1; DmemAddr out 32 (word-aligned, ALUResultM with [1:0]=00); DmemBe out 4; DmemWData out 32; DmemAck in 1; DmemRData in 32.
REQ-004 The block SHALL have these outputs: StallM out 1 (hold IF/ID/EX/M); MisalignM out 1; RegWriteW out 1; ResultSrcW out 2; RdW out 5; PCPlus4W, ReadDataW, ALUResultW out 32 each, all registered, feeding writeback.

Function
REQ-005 The block SHALL treat an M-stage instruction as a memory op when MemWriteM=1 (store) or ResultSrcM=01 (load); any other instruction is a non-memory op.
REQ-006 The block SHALL register a non-memory op into all W outputs at the next CLK edge, with 1-cycle latency, DmemReq=0 and StallM=0.
REQ-007 The block SHALL implement a two-state FSM, IDLE and WAIT, with reset state IDLE.
REQ-008 In IDLE, for an aligned memory op, the block SHALL assert DmemReq combinationally in the same cycle, with DmemWe=MemWriteM.
REQ-009 In IDLE with DmemAck=1 in the same cycle (zero-wait), the block SHALL complete the op: StallM=0, W registers load at the edge, and the FSM stays IDLE.
REQ-010 In IDLE with DmemAck=0, the block SHALL assert StallM=1 and go to WAIT.
REQ-011 In WAIT, the block SHALL hold DmemReq=1 and keep DmemAddr, DmemWe, DmemBe and DmemWData stable.
REQ-012 In WAIT, StallM SHALL equal ~DmemAck.
REQ-013 In WAIT, on DmemAck=1 the block SHALL load the W registers at that edge and return to IDLE.
REQ-014 On each edge where StallM=1, the block SHALL write a bubble into W: RegWriteW=0, with the other W fields holding their previous values.
REQ-015 The block SHALL ignore DmemAck while DmemReq=0.
REQ-016 The block SHALL generate store byte-enables from Funct3M and ALUResultM[1:0]: SB (000) gives 4'b0001<<addr[1:0]; SH (001) gives addr[1] ? 1100 : 0011; SW (010) gives 1111.
REQ-017 DmemWData SHALL replicate the store lanes: byte replicated x4 for SB, halfword x2 for SH, the full word for SW.
REQ-018 The block SHALL extract load data from DmemRData by addr[1:0]: LB (000) and LH (001) sign-extend; LW (010) passes the full word; LBU (100) and LHU (101) zero-extend. The result SHALL be registered into ReadDataW on completion.
REQ-019 For a load, DmemBe SHALL be 1111.
REQ-020 The block SHALL treat as misaligned a halfword op with addr[0]=1 or a word op with addr[1:0]!=00.
REQ-021 For a misaligned op, the block SHALL assert no DmemReq and keep StallM=0.
REQ-022 For a misaligned op, MisalignM SHALL be 1 combinationally for that cycle, and the W stage SHALL register the op with RegWriteW=0.
REQ-023 For a store, RegWriteW SHALL follow RegWriteM, which is 0 for a well-formed store; ReadDataW SHALL be don't-care.
REQ-024 The other W fields (ResultSrcW, RdW, PCPlus4W, ALUResultW) SHALL pass through from M unchanged.

Reset
REQ-025 RESET=1 SHALL asynchronously force the FSM to IDLE and clear RegWriteW, ResultSrcW, RdW, PCPlus4W, ReadDataW and ALUResultW to 0.
REQ-026 While RESET=1, DmemReq, StallM and MisalignM SHALL be 0.
REQ-027 RESET asserted in WAIT SHALL abandon the outstanding request: DmemReq drops immediately, a late DmemAck after release is ignored per REQ-015, and the aborted op never reaches W.
REQ-028 After RESET deasserts, the first op SHALL be accepted at the next CLK edge.

Verification
REQ-029 Bench: ADD (ResultSrcM=00, RegWriteM=1, RdM=5, ALUResultM=0x1234) -> next edge RegWriteW=1, RdW=5, ALUResultW=0x1234, StallM=0, DmemReq=0.
REQ-030 Bench: LB at addr 0x103 with DmemRData=0x80FFFFFF, ack after 3 wait cycles -> DmemAddr=0x100, StallM=1 for 3 cycles, bubbles with RegWriteW=0, then ReadDataW=0xFFFFFF80.
REQ-031 Bench: SH at 0x202 with WriteDataM=0xABCD1234 and zero-wait ack -> DmemBe=1100, DmemWData=0x12341234, DmemWe=1, StallM=0.
REQ-032 Bench: LW at 0x301 -> MisalignM=1, DmemReq=0, next edge RegWriteW=0, StallM=0.
REQ-033 Bench: LHU at 0x402 with DmemRData=0xF00D0000 and zero-wait ack -> ReadDataW=0x0000F00D, no stall.
REQ-034 Bench: RESET pulsed in WAIT, then DmemAck=1 after release -> DmemReq=0 immediately, FSM IDLE, all W outputs 0, the ack causes no W update.
